frame_buffer_writer: RTL and testbench

Upstream stage of the VGA display path. Accepts the 8-bit grayscale pixel stream from the Sobel filter through a valid/ready handshake with start-of-frame marking, and writes each pixel into the shared 640x480 BRAM frame buffer at linear address y*640+x. The display block reads the same buffer from its own port. A raster counter generates addresses, so no multiplier is used. The block reports frame completion and resynchronisation errors.

---
 rtl/vga_pkg.sv | 17 +
 rtl/frame_buffer_writer_if.sv | 26 ++
 rtl/raster_counter.sv | 49 ++++
 rtl/frame_buffer_writer.sv | 139 +++++++++++++
 tb/tb_frame_buffer_writer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Constants and types shared by the VGA frame-buffer writer and the display reader.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int FB_DEPTH     = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int FB_ADDR_W    = 19;
    localparam int PIX_W        = 8;
    localparam int XY_W         = 10;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wr_state_t;

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel-stream handshake plus BRAM write port of the frame-buffer writer.
interface frame_buffer_writer_if
    import vga_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = FB_ADDR_W
);
    logic              sobelready;
    logic              transmit_valid;
    logic              pix_sof;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;

    modport master (
        output sobelready, transmit_valid, pix_sof, pix_data,
        input  pix_ready, bram_addr, bram_din, bram_we
    );

    modport slave (
        input  sobelready, transmit_valid, pix_sof, pix_data,
        output pix_ready, bram_addr, bram_din, bram_we
    );
endinterface

// File: rtl/raster_counter.sv
// Raster x/y and linear-address counter; clear together with advance lands on pixel (1,0).
module raster_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = FB_ADDR_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [XY_W-1:0]   x,
    output logic [XY_W-1:0]   y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [XY_W-1:0]   x_reg;
    logic [XY_W-1:0]   y_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              line_end;

    assign line_end = (x_reg == XY_W'(H_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg    <= '0;
            y_reg    <= '0;
            addr_reg <= '0;
        end else if (clear) begin
            x_reg    <= advance ? XY_W'(1) : '0;
            y_reg    <= '0;
            addr_reg <= advance ? ADDR_W'(1) : '0;
        end else if (advance) begin
            if (line_end) begin
                x_reg <= '0;
                y_reg <= y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
            addr_reg <= addr_reg + 1'b1;
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign addr = addr_reg;
    assign last = line_end && (y_reg == XY_W'(V_ACTIVE - 1));
endmodule

// File: rtl/frame_buffer_writer.sv
// Writes the Sobel pixel stream into the shared frame buffer at raster order addresses.
// Build option BINARIZE_EN thresholds each pixel to all-ones/zero before writing.
module frame_buffer_writer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = PIX_W,
    parameter int BIN_THRESH = 128
)(
    input  logic                 clk,
    input  logic                 rst_n,
    frame_buffer_writer_if.slave bus,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 busy
);
    if (H_ACTIVE * V_ACTIVE > (1 << ADDR_W)) begin : g_addr_check
        $error("frame does not fit in ADDR_W address bits");
    end
    if (BIN_THRESH < 0 || BIN_THRESH >= (1 << DATA_W)) begin : g_thresh_check
        $error("BIN_THRESH outside the pixel range");
    end

    wr_state_t         state_reg;
    logic              pix_ready_reg;
    logic              bram_we_reg;
    logic [ADDR_W-1:0] bram_addr_reg;
    logic [DATA_W-1:0] bram_din_reg;
    logic              frame_done_reg;
    logic              sync_err_reg;
    logic              busy_reg;

    logic [XY_W-1:0]   cnt_x;
    logic [XY_W-1:0]   cnt_y;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;

    logic              accept;
    logic              at_origin;
    logic              start;
    logic              resync;
    logic              step;
    logic              finish;
    logic              write_now;
    logic              cnt_clear;
    logic              cnt_adv;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] din_val;

    assign accept    = bus.transmit_valid && pix_ready_reg;
    assign at_origin = (cnt_x == '0) && (cnt_y == '0);
    assign start     = (state_reg == IDLE) && accept && bus.pix_sof && bus.sobelready;
    assign resync    = (state_reg == WRITE) && accept && bus.pix_sof && !at_origin;
    assign step      = (state_reg == WRITE) && accept && !resync;
    assign finish    = step && cnt_last;
    assign write_now = start || resync || step;

    // The last pixel clears instead of advancing so the address never runs past the frame.
    assign cnt_clear  = start || resync || finish || (state_reg == DONE);
    assign cnt_adv    = start || resync || (step && !cnt_last);
    assign write_addr = (start || resync) ? '0 : cnt_addr;

`ifdef BINARIZE_EN
    assign din_val = (bus.pix_data >= DATA_W'(BIN_THRESH)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`else
    assign din_val = bus.pix_data;
`endif

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .x       (cnt_x),
        .y       (cnt_y),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pix_ready_reg  <= 1'b0;
            bram_we_reg    <= 1'b0;
            bram_addr_reg  <= '0;
            bram_din_reg   <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            bram_we_reg    <= write_now;
            sync_err_reg   <= resync;
            frame_done_reg <= (state_reg == DONE);
            if (write_now) begin
                bram_addr_reg <= write_addr;
                bram_din_reg  <= din_val;
            end
            case (state_reg)
                IDLE: begin
                    pix_ready_reg <= 1'b1;
                    if (start) begin
                        state_reg <= WRITE;
                        busy_reg  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (finish) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        pix_ready_reg <= 1'b0;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    pix_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    pix_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_reg;
    assign bus.bram_we   = bram_we_reg;
    assign bus.bram_addr = bram_addr_reg;
    assign bus.bram_din  = bram_din_reg;
    assign frame_done    = frame_done_reg;
    assign sync_err      = sync_err_reg;
    assign busy          = busy_reg;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer; a 640x8 frame keeps full-frame runs short.
module tb_frame_buffer_writer;
    import vga_pkg::*;

    localparam int H    = 640;
    localparam int V    = 8;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done;
    logic sync_err;
    logic busy;

    frame_buffer_writer_if fb_if ();

    frame_buffer_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (fb_if),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int nr_cnt = 0;
    int fd_cyc = 0;
    int last_wr_cyc = 0;
    int wr_addr[$];
    int wr_din[$];
    int wr_serr[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_if.bram_we) begin
            wr_addr.push_back(int'(fb_if.bram_addr));
            wr_din.push_back(int'(fb_if.bram_din));
            wr_serr.push_back(int'(sync_err));
            last_wr_cyc = cyc;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (sync_err) se_cnt++;
        if (!fb_if.pix_ready) nr_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_din.delete();
        wr_serr.delete();
        fd_cnt = 0;
        se_cnt = 0;
        nr_cnt = 0;
    endtask

    task automatic push(input logic sof, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        fb_if.transmit_valid = 1'b1;
        fb_if.pix_sof        = sof;
        fb_if.pix_data       = d;
        while (!fb_if.pix_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", int'(t < 20), 1);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            fb_if.transmit_valid = 1'b0;
            fb_if.pix_sof        = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fb_if.transmit_valid = 1'b0;
        fb_if.pix_sof = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int e0;
        int exp_din [3];
        fb_if.sobelready     = 1'b1;
        fb_if.transmit_valid = 1'b0;
        fb_if.pix_sof        = 1'b0;
        fb_if.pix_data       = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pix_ready", int'(fb_if.pix_ready), 0);
        check_eq("rst_we", int'(fb_if.bram_we), 0);
        check_eq("rst_addr", int'(fb_if.bram_addr), 0);
        check_eq("rst_din", int'(fb_if.bram_din), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        check_eq("rst_sync_err", int'(sync_err), 0);
        check_eq("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", int'(fb_if.pix_ready), 1);
        @(posedge clk);
        $display("reset checks done");

        // Full frame
        clear_log();
        push(1'b1, 8'h00);
        for (int i = 1; i < NPIX; i++) push(1'b0, 8'(i));
        gap(4);
        check_eq("frame_wr_count", wr_addr.size(), NPIX);
        e0 = errors;
        for (int i = 0; i < wr_addr.size(); i++) begin
            check_eq("frame_addr", wr_addr[i], i);
            check_eq("frame_din", wr_din[i], i % 256);
            if (errors != e0) break;
        end
        check_eq("frame_done_count", fd_cnt, 1);
        check_eq("frame_done_timing", fd_cyc, last_wr_cyc + 1);
        check_eq("ready_low_cycles", nr_cnt, 1);
        check_eq("frame_sync_err", se_cnt, 0);
        check_eq("busy_after_frame", int'(busy), 0);
        $display("full frame: %0d writes, frame_done %0d", wr_addr.size(), fd_cnt);

        // IDLE filtering
        clear_log();
        for (int i = 0; i < 10; i++) push(1'b0, 8'(i + 1));
        gap(3);
        check_eq("idle_no_sof_writes", wr_addr.size(), 0);
        fb_if.sobelready = 1'b0;
        push(1'b1, 8'h55);
        gap(3);
        check_eq("idle_not_ready_writes", wr_addr.size(), 0);
        check_eq("idle_not_ready_busy", int'(busy), 0);
        fb_if.sobelready = 1'b1;
        push(1'b1, 8'hA5);
        gap(3);
        check_eq("sof_wr_count", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            check_eq("sof_addr", wr_addr[0], 0);
            check_eq("sof_din", wr_din[0], 8'hA5);
        end
        check_eq("sof_busy", int'(busy), 1);
        $display("idle filtering: %0d writes", wr_addr.size());

        // Line wrap with gaps; frame continues at pixel 1
        clear_log();
        for (int i = 1; i < 2 * H; i++) begin
            push(1'b0, 8'(i));
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end
        gap(3);
        check_eq("wrap_wr_count", wr_addr.size(), 2 * H - 1);
        if (wr_addr.size() == 2 * H - 1) begin
            check_eq("wrap_addr_640", wr_addr[639], 640);
            check_eq("wrap_din_640", wr_din[639], 128);
            check_eq("wrap_addr_1279", wr_addr[1278], 1279);
            check_eq("wrap_din_1279", wr_din[1278], 255);
        end
        check_eq("wrap_frame_done", fd_cnt, 0);
        $display("line wrap: %0d writes", wr_addr.size());

        // Mid-frame SOF after 1000 pixels
        do_reset();
        push(1'b1, 8'h00);
        for (int i = 1; i < 1000; i++) push(1'b0, 8'(i));
        gap(2);
        clear_log();
        push(1'b1, 8'h3C);
        push(1'b0, 8'h3D);
        gap(3);
        check_eq("resync_wr_count", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check_eq("resync_addr0", wr_addr[0], 0);
            check_eq("resync_din0", wr_din[0], 8'h3C);
            check_eq("resync_err0", wr_serr[0], 1);
            check_eq("resync_addr1", wr_addr[1], 1);
            check_eq("resync_din1", wr_din[1], 8'h3D);
            check_eq("resync_err1", wr_serr[1], 0);
        end
        check_eq("resync_err_count", se_cnt, 1);
        check_eq("resync_frame_done", fd_cnt, 0);
        $display("mid-frame sof: sync_err %0d", se_cnt);

        // Reset at pixel 5000
        do_reset();
        push(1'b1, 8'h00);
        for (int i = 1; i <= 5000; i++) push(1'b0, 8'(i));
        @(negedge clk);
        rst_n = 1'b0;
        fb_if.transmit_valid = 1'b0;
        check_eq("pre_rst_we", int'(fb_if.bram_we), 1);
        check_eq("pre_rst_addr", int'(fb_if.bram_addr), 5000);
        @(negedge clk);
        check_eq("midrst_we", int'(fb_if.bram_we), 0);
        check_eq("midrst_addr", int'(fb_if.bram_addr), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_ready", int'(fb_if.pix_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        clear_log();
        for (int i = 0; i < 5; i++) push(1'b0, 8'(i + 9));
        gap(3);
        check_eq("midrst_dropped", wr_addr.size(), 0);
        push(1'b1, 8'h77);
        gap(3);
        check_eq("midrst_sof_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check_eq("midrst_sof_addr", wr_addr[0], 0);
            check_eq("midrst_sof_din", wr_din[0], 8'h77);
        end
        $display("reset at pixel 5000: %0d writes after restart", wr_addr.size());

        // Threshold boundary values; frame continues at pixel 1
`ifdef BINARIZE_EN
        exp_din = '{0, 255, 255};
`else
        exp_din = '{127, 128, 255};
`endif
        clear_log();
        push(1'b0, 8'd127);
        push(1'b0, 8'd128);
        push(1'b0, 8'd255);
        gap(3);
        check_eq("thresh_wr_count", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("thresh_addr", wr_addr[i], i + 1);
                check_eq("thresh_din", wr_din[i], exp_din[i]);
            end
        end
        $display("threshold pixels: %0d writes", wr_addr.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
